// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - CPU, DMA and data-RAM port bundle for dmem_port_arbiter
// slave = arbiter side, master = requesters plus RAM read data.
interface dmem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 7
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic          err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - single-port data RAM arbiter between CPU MEM stage and DMA port
// Fixed CPU priority with DMA starvation guard; DMEM_ARB_RR_EN selects round-robin instead.
module dmem_port_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 7,
  parameter int DEPTH    = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic          gnt_cpu;
  logic          gnt_dma;
  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_range;

  logic          cpu_rvalid_q;
  logic          dma_rvalid_q;
  logic          rsp_oor;
  logic          err_q;
  logic [DW-1:0] cpu_hold;
  logic [DW-1:0] dma_hold;
  logic [DW-1:0] rsp_data;

`ifdef DMEM_ARB_RR_EN
  // Resets to DMA so the CPU takes the first tie.
  logic last_dma;

  always_comb begin
    gnt_cpu = bus.cpu_req & (~bus.dma_req | last_dma);
    gnt_dma = bus.dma_req & ~gnt_cpu;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dma <= 1'b1;
    end else if (gnt_cpu | gnt_dma) begin
      last_dma <= gnt_dma;
    end
  end
`else
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;
  logic          starve;

  assign starve = (wait_cnt == WW'(MAX_WAIT));

  always_comb begin
    gnt_dma = bus.dma_req & (starve | ~bus.cpu_req);
    gnt_cpu = bus.cpu_req & ~gnt_dma;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (~bus.dma_req | gnt_dma) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end
`endif

  assign any_gnt = gnt_cpu | gnt_dma;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_dma) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end else if (gnt_cpu) begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end
  end

  assign in_range      = ({1'b0, sel_addr} < DEPTH_LIM);

  assign bus.mem_en    = any_gnt & in_range;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  assign bus.cpu_gnt   = gnt_cpu;
  assign bus.dma_gnt   = gnt_dma;
  assign bus.cpu_stall = bus.cpu_req & ~gnt_cpu;

  // The rvalid flags double as the response owner tag travelling with the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      rsp_oor      <= 1'b0;
      err_q        <= 1'b0;
      cpu_hold     <= '0;
      dma_hold     <= '0;
    end else begin
      cpu_rvalid_q <= gnt_cpu & ~bus.cpu_we;
      dma_rvalid_q <= gnt_dma & ~bus.dma_we;
      rsp_oor      <= ~in_range;
      err_q        <= any_gnt & ~in_range;
      if (cpu_rvalid_q) cpu_hold <= rsp_data;
      if (dma_rvalid_q) dma_hold <= rsp_data;
    end
  end

  // RAM data only arrives in the response cycle, so it is passed through then and held after.
  assign rsp_data       = rsp_oor ? '0 : bus.mem_rdata;

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.cpu_rdata  = cpu_rvalid_q ? rsp_data : cpu_hold;
  assign bus.dma_rdata  = dma_rvalid_q ? rsp_data : dma_hold;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter (DEPTH=64)
// Includes a behavioural 1-cycle-latency RAM model on the memory port.
module tb_dmem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 7;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] ram [0:127];

  int exp_cpu [6];
  int exp_dma [6];

  dmem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  dmem_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(64), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;

    // Reset state
    @(negedge clk);
    check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst_dma_rvalid", bus.dma_rvalid, 0);
    check("rst_err", bus.err, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_dma_rdata", bus.dma_rdata, 0);
    check("rst_mem_en", bus.mem_en, 0);
    tick();
    reset = 1'b0;

    // Both ports requesting continuously
`ifdef DMEM_ARB_RR_EN
    exp_cpu = '{1, 0, 1, 0, 1, 0};
    exp_dma = '{0, 1, 0, 1, 0, 1};
`else
    exp_cpu = '{1, 1, 1, 1, 0, 1};
    exp_dma = '{0, 0, 0, 0, 1, 0};
`endif
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'd20; bus.cpu_wdata = 32'd1;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 7'd21; bus.dma_wdata = 32'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("arb_cpu_gnt_c%0d", i + 1), bus.cpu_gnt, exp_cpu[i]);
      check($sformatf("arb_dma_gnt_c%0d", i + 1), bus.dma_gnt, exp_dma[i]);
      check($sformatf("arb_cpu_stall_c%0d", i + 1), bus.cpu_stall, exp_dma[i]);
      tick();
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    @(negedge clk);
    check("arb_idle_cpu_gnt", bus.cpu_gnt, 0);
    check("arb_idle_dma_gnt", bus.dma_gnt, 0);
    check("arb_idle_mem_we", bus.mem_we, 0);
    tick();

    // CPU write 42 <- 123, then read 42
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'd42; bus.cpu_wdata = 32'd123;
    @(negedge clk);
    check("wr42_gnt", bus.cpu_gnt, 1);
    check("wr42_stall", bus.cpu_stall, 0);
    check("wr42_mem_en", bus.mem_en, 1);
    check("wr42_mem_we", bus.mem_we, 1);
    check("wr42_mem_addr", bus.mem_addr, 42);
    check("wr42_mem_wdata", bus.mem_wdata, 123);
    tick();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    check("rd42_gnt", bus.cpu_gnt, 1);
    check("rd42_stall", bus.cpu_stall, 0);
    check("rd42_mem_we", bus.mem_we, 0);
    check("wr42_no_rvalid", bus.cpu_rvalid, 0);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rd42_rvalid", bus.cpu_rvalid, 1);
    check("rd42_rdata", bus.cpu_rdata, 123);
    check("rd42_err", bus.err, 0);
    check("rd42_stall_idle", bus.cpu_stall, 0);
    tick();
    @(negedge clk);
    check("rd42_rvalid_pulse", bus.cpu_rvalid, 0);
    check("rd42_rdata_hold", bus.cpu_rdata, 123);
    tick();

    // Back-to-back reads of 50 and 42
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'd50; bus.cpu_wdata = 32'd321;
    @(negedge clk);
    check("wr50_gnt", bus.cpu_gnt, 1);
    tick();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    check("b2b_rd50_gnt", bus.cpu_gnt, 1);
    check("b2b_rd50_mem_addr", bus.mem_addr, 50);
    tick();
    bus.cpu_addr = 7'd42;
    @(negedge clk);
    check("b2b_rd42_gnt", bus.cpu_gnt, 1);
    check("b2b_rvalid_1", bus.cpu_rvalid, 1);
    check("b2b_rdata_1", bus.cpu_rdata, 321);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("b2b_rvalid_2", bus.cpu_rvalid, 1);
    check("b2b_rdata_2", bus.cpu_rdata, 123);
    tick();
    @(negedge clk);
    check("b2b_rvalid_end", bus.cpu_rvalid, 0);
    tick();

    // Out-of-range DMA read and CPU write
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 7'd100;
    @(negedge clk);
    check("oor_rd_dma_gnt", bus.dma_gnt, 1);
    check("oor_rd_cpu_gnt", bus.cpu_gnt, 0);
    check("oor_rd_mem_en", bus.mem_en, 0);
    tick();
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'd70; bus.cpu_wdata = 32'd5;
    @(negedge clk);
    check("oor_rd_dma_rvalid", bus.dma_rvalid, 1);
    check("oor_rd_dma_rdata", bus.dma_rdata, 0);
    check("oor_rd_err", bus.err, 1);
    check("oor_rd_cpu_rvalid", bus.cpu_rvalid, 0);
    check("oor_wr_gnt", bus.cpu_gnt, 1);
    check("oor_wr_mem_en", bus.mem_en, 0);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("oor_wr_err", bus.err, 1);
    check("oor_wr_no_rvalid", bus.cpu_rvalid, 0);
    check("oor_rd_dma_rvalid_pulse", bus.dma_rvalid, 0);
    tick();
    @(negedge clk);
    check("oor_err_pulse", bus.err, 0);
    tick();

    // Reset during a pending read response
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'd42;
    @(negedge clk);
    check("rstrd_gnt", bus.cpu_gnt, 1);
    tick();
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rstrd_rvalid", bus.cpu_rvalid, 0);
    check("rstrd_rdata", bus.cpu_rdata, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstrd_no_rsp_%0d", i), bus.cpu_rvalid, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
